// File: rtl/uart_rx_port.sv
// uart_rx_port - receive side of the IO serial channel.
//
// Deserialises an 8N1 UART line into a byte FIFO. The CPU sees two
// registers in its IO slot:
//   addr[3:2] = 0  DATA   : read pops the FIFO head (0 when empty), writes ignored
//   addr[3:2] = 1  STATUS : [0] not_empty [1] full [2] OVR [3] FERR [4] PERR
//                           [15:8] count; writing 1 to bit 2/3/4 clears that flag
//   other offsets read 0, writes ignored.
//
// Ports:
//   clk    core clock, sole clock domain
//   reset  synchronous, active-high reset
//   cs     slot select, one access per cycle while high
//   ready  access complete (zero wait states, equals cs)
//   addr   byte address, addr[3:2] selects the register
//   wdata  write data (STATUS W1C bits only)
//   rdata  read data, combinational, 0 unless cs && !we
//   we     1 = write, 0 = read
//   rx     asynchronous serial input, idle high
//
// Build option: define UART_RX_PARITY_EN to expect an even parity bit
// between the data bits and the stop bit (mismatch sets PERR, byte is kept).
// Without it the frame is 8N1, STATUS[4] reads 0 and W1C on bit 4 is a no-op.

module uart_rx_port #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        we,
    input  logic        rx
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int NW  = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Even parity: the expected parity bit is the XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [1:0]      settle;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            push_req;
    logic            ferr_set;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [NW-1:0]   count;
    logic            ovr;
    logic            ferr;
    logic            perr;
    logic [1:0]      reg_sel;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            clr;
    logic [31:0]     status;

    assign reg_sel = addr[3:2];
    assign full    = (count == NW'(FIFO_DEPTH));
    assign pop     = cs && !we && (reg_sel == 2'd0) && (count != NW'(0));
    // A push into a full FIFO only lands if a pop frees the slot this cycle.
    assign push_ok = push_req && (!full || pop);
    assign clr     = cs && we && (reg_sel == 2'd1);
    assign ready   = cs;

`ifdef UART_RX_PARITY_EN
    logic perr_set;
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:5], wdata[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:4], wdata[1:0]};
    assign perr = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous line, idle-high at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Arm start detection only once the line is seen high after the
    // synchroniser has flushed its reset value, so a line held low across
    // reset is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if ((settle == 2'd2) && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame receiver FSM with bit-centre sampling on baud counter expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= CW'(0);
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            push_req <= 1'b0;
            ferr_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_set <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            ferr_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_set <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (armed && !rx_s) begin
                        state <= S_START;
                        cnt   <= CW'(DIV / 2 - 1);
                    end
                end
                S_START: begin
                    if (cnt != CW'(0)) begin
                        cnt <= cnt - CW'(1);
                    end else if (!rx_s) begin
                        state   <= S_DATA;
                        cnt     <= CW'(DIV - 1);
                        bit_idx <= 3'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt != CW'(0)) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // LSB arrives first, so shift in from the top.
                        shift   <= {rx_s, shift[7:1]};
                        cnt     <= CW'(DIV - 1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt != CW'(0)) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        perr_set <= (rx_s != even_parity(shift));
                        cnt      <= CW'(DIV - 1);
                        state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt != CW'(0)) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_s) begin
                        push_req <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        ferr_set <= 1'b1;
                        state    <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; pointers make stale contents unreachable after reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= PW'(0);
            rd_ptr <= PW'(0);
            count  <= NW'(0);
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + NW'(1);
            end else if (!push_ok && pop) begin
                count <= count - NW'(1);
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            ovr  <= (push_req && full && !pop) || (ovr && !(clr && wdata[2]));
            ferr <= ferr_set || (ferr && !(clr && wdata[3]));
`ifdef UART_RX_PARITY_EN
            perr <= perr_set || (perr && !(clr && wdata[4]));
`endif
        end
    end

    // Register read mux.
    always_comb begin
        status       = 32'd0;
        status[0]    = (count != NW'(0));
        status[1]    = full;
        status[2]    = ovr;
        status[3]    = ferr;
        status[4]    = perr;
        status[15:8] = 8'(count);
        rdata        = 32'd0;
        if (cs && !we) begin
            case (reg_sel)
                2'd0: begin
                    if (count != NW'(0)) begin
                        rdata = {24'd0, mem[rd_ptr]};
                    end else begin
                        rdata = 32'd0;
                    end
                end
                2'd1:    rdata = status;
                default: rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

endmodule
